// File: rtl/l2_port_arbiter_pkg.sv
// Shared definitions for the L1-to-L2 port arbiter: FSM states, port indices
// and default bus widths.
package l2_port_arbiter_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_ADDR_WIDTH = 32;

    localparam int NUM_PORTS = 2;
    localparam int PORT_IC   = 0;
    localparam int PORT_DC   = 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RESPOND = 2'd2
    } arb_state_t;

endpackage

// File: rtl/l2_port_arbiter_rr.sv
// Two-way round-robin arbiter: one-hot grant while enabled, remembers the
// last winner so contention always alternates.
module rr_arbiter_2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] grant,
    output logic       last_grant
);

    logic last_grant_reg;

    always_comb begin
        grant = 2'b00;
        if (en) begin
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_grant_reg ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    // Reset value 1 gives port 0 the first contended grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_reg <= 1'b1;
        end else if (|grant) begin
            last_grant_reg <= grant[1];
        end
    end

    assign last_grant = last_grant_reg;

endmodule

// File: rtl/l2_port_arbiter.sv
// Shares the L2 cache's L1-side port between the instruction and data L1s,
// one outstanding transaction at a time with a WAIT timeout.
module l2_port_arbiter
    import l2_port_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] ic_addr,
    input  logic [DATA_WIDTH-1:0] ic_data_in,
    input  logic                  ic_read,
    input  logic                  ic_write,
    output logic [DATA_WIDTH-1:0] ic_data_out,
    output logic                  ic_ready,
    output logic                  ic_hit,
    output logic                  ic_err,
    input  logic [ADDR_WIDTH-1:0] dc_addr,
    input  logic [DATA_WIDTH-1:0] dc_data_in,
    input  logic                  dc_read,
    input  logic                  dc_write,
    output logic [DATA_WIDTH-1:0] dc_data_out,
    output logic                  dc_ready,
    output logic                  dc_hit,
    output logic                  dc_err,
    output logic [ADDR_WIDTH-1:0] l2_addr,
    output logic [DATA_WIDTH-1:0] l2_data_out,
    input  logic [DATA_WIDTH-1:0] l2_data_in,
    output logic                  l2_read,
    output logic                  l2_write,
    input  logic                  l2_ready,
    input  logic                  l2_hit,
    output logic                  busy
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    arb_state_t state_reg, state_next;

    logic [CNT_W-1:0]      cnt_reg;
    logic [ADDR_WIDTH-1:0] l2_addr_reg;
    logic [DATA_WIDTH-1:0] l2_data_reg;
    logic                  l2_read_reg;
    logic                  l2_write_reg;
    logic                  busy_reg;

    logic [NUM_PORTS-1:0]  req;
    logic [ADDR_WIDTH-1:0] req_addr [NUM_PORTS];
    logic [DATA_WIDTH-1:0] req_data [NUM_PORTS];
    logic                  req_wr   [NUM_PORTS];

    logic [1:0] grant;
    logic       owner;
    logic       sel;
    logic       at_limit;
    logic       finish;

    assign req[PORT_IC]      = ic_read | ic_write;
    assign req[PORT_DC]      = dc_read | dc_write;
    assign req_addr[PORT_IC] = ic_addr;
    assign req_addr[PORT_DC] = dc_addr;
    assign req_data[PORT_IC] = ic_data_in;
    assign req_data[PORT_DC] = dc_data_in;
    assign req_wr[PORT_IC]   = ic_write;
    assign req_wr[PORT_DC]   = dc_write;

    rr_arbiter_2 u_rr (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (state_reg == ST_IDLE),
        .req        (req),
        .grant      (grant),
        .last_grant (owner)
    );

    // last_grant is updated on the grant edge, so it names the owner of the
    // transaction for the whole of WAIT and RESPOND.
    assign sel      = grant[PORT_DC];
    assign at_limit = (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
    assign finish   = (state_reg == ST_WAIT) && (l2_ready || at_limit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:    if (|grant) state_next = ST_WAIT;
            ST_WAIT:    if (finish) state_next = ST_RESPOND;
            ST_RESPOND: state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg      <= '0;
            l2_addr_reg  <= '0;
            l2_data_reg  <= '0;
            l2_read_reg  <= 1'b0;
            l2_write_reg <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            busy_reg <= (state_next != ST_IDLE);
            if (state_reg == ST_IDLE && (|grant)) begin
                // A simultaneous read+write is issued as a write.
                l2_addr_reg  <= req_addr[sel];
                l2_data_reg  <= req_data[sel];
                l2_write_reg <= req_wr[sel];
                l2_read_reg  <= ~req_wr[sel];
                cnt_reg      <= '0;
            end else if (state_reg == ST_WAIT) begin
                if (finish) begin
                    l2_read_reg  <= 1'b0;
                    l2_write_reg <= 1'b0;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            localparam logic PORT_ID = 1'(gi);

            logic [DATA_WIDTH-1:0] data_out_reg;
            logic                  ready_reg;
            logic                  hit_reg;
            logic                  err_reg;
            logic                  owns;

            assign owns = (owner == PORT_ID);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_out_reg <= '0;
                    ready_reg    <= 1'b0;
                    hit_reg      <= 1'b0;
                    err_reg      <= 1'b0;
                end else if (state_reg == ST_WAIT && owns) begin
                    if (l2_ready) begin
                        data_out_reg <= l2_data_in;
                        hit_reg      <= l2_hit;
                        err_reg      <= 1'b0;
                        ready_reg    <= 1'b1;
                    end else if (at_limit) begin
                        hit_reg   <= 1'b0;
                        err_reg   <= 1'b1;
                        ready_reg <= 1'b1;
                    end
                end else if (state_reg == ST_RESPOND) begin
                    ready_reg <= 1'b0;
                    hit_reg   <= 1'b0;
                    err_reg   <= 1'b0;
                end
            end
        end
    endgenerate

    assign ic_data_out = g_port[PORT_IC].data_out_reg;
    assign ic_ready    = g_port[PORT_IC].ready_reg;
    assign ic_hit      = g_port[PORT_IC].hit_reg;
    assign ic_err      = g_port[PORT_IC].err_reg;
    assign dc_data_out = g_port[PORT_DC].data_out_reg;
    assign dc_ready    = g_port[PORT_DC].ready_reg;
    assign dc_hit      = g_port[PORT_DC].hit_reg;
    assign dc_err      = g_port[PORT_DC].err_reg;

    assign l2_addr     = l2_addr_reg;
    assign l2_data_out = l2_data_reg;
    assign l2_read     = l2_read_reg;
    assign l2_write    = l2_write_reg;
    assign busy        = busy_reg;

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Randomized scoreboard bench for l2_port_arbiter with a transaction-level
// reference model, an L2 responder and a response monitor.
module tb_l2_port_arbiter;

    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int TMO = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] ic_addr = '0, dc_addr = '0;
    logic [DW-1:0] ic_data_in = '0, dc_data_in = '0;
    logic          ic_read = 1'b0, ic_write = 1'b0, dc_read = 1'b0, dc_write = 1'b0;
    logic [DW-1:0] ic_data_out, dc_data_out;
    logic          ic_ready, ic_hit, ic_err, dc_ready, dc_hit, dc_err;
    logic [AW-1:0] l2_addr;
    logic [DW-1:0] l2_data_out;
    logic [DW-1:0] l2_data_in = '0;
    logic          l2_read, l2_write;
    logic          l2_ready = 1'b0, l2_hit = 1'b0;
    logic          busy;

    l2_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .ic_addr(ic_addr), .ic_data_in(ic_data_in), .ic_read(ic_read), .ic_write(ic_write),
        .ic_data_out(ic_data_out), .ic_ready(ic_ready), .ic_hit(ic_hit), .ic_err(ic_err),
        .dc_addr(dc_addr), .dc_data_in(dc_data_in), .dc_read(dc_read), .dc_write(dc_write),
        .dc_data_out(dc_data_out), .dc_ready(dc_ready), .dc_hit(dc_hit), .dc_err(dc_err),
        .l2_addr(l2_addr), .l2_data_out(l2_data_out), .l2_data_in(l2_data_in),
        .l2_read(l2_read), .l2_write(l2_write), .l2_ready(l2_ready), .l2_hit(l2_hit),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        bit          hit;
        logic [31:0] rdata;
    } req_t;

    typedef struct {
        int          port;
        logic [31:0] data;
        bit          hit;
        bit          err;
        int          cyc;
        logic [31:0] other;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        bit          rd;
        bit          wr;
        bit          hit;
        bit          abort;
        int          lat;
    } plan_t;

    req_t        cur [2];
    exp_t        sb [$];
    plan_t       l2q [$];
    int          model_last = 1;
    logic [31:0] model_data [2] = '{32'h0, 32'h0};

    function automatic req_t mk_req(input bit rd, input bit wr, input logic [31:0] addr,
                                    input logic [31:0] wdata, input int lat, input bit hit,
                                    input logic [31:0] rdata);
        req_t r;
        r.rd = rd; r.wr = wr; r.addr = addr; r.wdata = wdata;
        r.lat = lat; r.hit = hit; r.rdata = rdata;
        return r;
    endfunction

    function automatic req_t rand_req();
        int op;
        op = $urandom_range(0, 2);
        return mk_req(op != 1, op != 0, $urandom, $urandom, $urandom_range(0, 5),
                      1'($urandom_range(0, 1)), $urandom);
    endfunction

    task automatic drive_port(input int p, input bit on);
        if (p == 0) begin
            ic_read  = on && cur[0].rd;
            ic_write = on && cur[0].wr;
            ic_addr    = on ? cur[0].addr  : $urandom;
            ic_data_in = on ? cur[0].wdata : $urandom;
        end else begin
            dc_read  = on && cur[1].rd;
            dc_write = on && cur[1].wr;
            dc_addr    = on ? cur[1].addr  : $urandom;
            dc_data_in = on ? cur[1].wdata : $urandom;
        end
    endtask

    // Reference model: serve requesters in round-robin order, predict the
    // response contents and the cycle of each ready pulse.
    task automatic do_round(input bit r_ic, input bit r_dc);
        bit want [2];
        int order [$];
        int t;
        want[0] = r_ic;
        want[1] = r_dc;
        @(negedge clk);
        t = cyc;
        if (r_ic && r_dc) begin
            order.push_back(model_last == 0 ? 1 : 0);
            order.push_back(model_last == 0 ? 0 : 1);
        end else begin
            order.push_back(r_ic ? 0 : 1);
        end
        foreach (order[k]) begin
            int    p;
            int    w;
            exp_t  e;
            plan_t pl;
            p = order[k];
            w = (cur[p].lat < TMO) ? cur[p].lat + 1 : TMO;
            e.port = p;
            e.cyc  = t + 1 + w;
            if (cur[p].lat < TMO) begin
                e.data = cur[p].rdata; e.hit = cur[p].hit; e.err = 1'b0;
                model_data[p] = cur[p].rdata;
            end else begin
                e.data = model_data[p]; e.hit = 1'b0; e.err = 1'b1;
            end
            e.other = model_data[1-p];
            sb.push_back(e);
            pl.addr = cur[p].addr; pl.wdata = cur[p].wdata; pl.rdata = cur[p].rdata;
            pl.wr = cur[p].wr; pl.rd = cur[p].rd && !cur[p].wr;
            pl.hit = cur[p].hit; pl.lat = cur[p].lat; pl.abort = 1'b0;
            l2q.push_back(pl);
            model_last = p;
            t = e.cyc + 1;
        end
        for (int p = 0; p < 2; p++) if (want[p]) drive_port(p, 1'b1);
        for (int n = 0; n < 300 && (want[0] || want[1]); n++) begin
            if (want[0] && ic_ready) begin want[0] = 0; drive_port(0, 1'b0); end
            if (want[1] && dc_ready) begin want[1] = 0; drive_port(1, 1'b0); end
            if (want[0] || want[1]) @(negedge clk);
        end
        if (want[0] || want[1]) begin
            n_checks++; n_fail++;
            $display("FAIL round_timeout: got no ready expected ready for ic=%0b dc=%0b", want[0], want[1]);
            drive_port(0, 1'b0);
            drive_port(1, 1'b0);
        end
    endtask

    // Monitor: compare every ready pulse against the scoreboard head.
    initial begin
        exp_t e;
        int   pa;
        forever begin
            @(negedge clk);
            if (rst_n && (ic_ready || dc_ready)) begin
                check("single_ready", {63'd0, ic_ready && dc_ready}, 64'd0);
                if (sb.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_ready: got ic=%0b dc=%0b expected none", ic_ready, dc_ready);
                end else begin
                    e  = sb.pop_front();
                    pa = dc_ready ? 1 : 0;
                    check("grant_port", 64'(pa), 64'(e.port));
                    check("ready_cycle", 64'(cyc), 64'(e.cyc));
                    if (pa == 0) begin
                        check("ic_data_out", 64'(ic_data_out), 64'(e.data));
                        check("ic_hit", 64'(ic_hit), 64'(e.hit));
                        check("ic_err", 64'(ic_err), 64'(e.err));
                        check("dc_data_held", 64'(dc_data_out), 64'(e.other));
                        check("dc_status_quiet", {62'd0, dc_hit, dc_err}, 64'd0);
                    end else begin
                        check("dc_data_out", 64'(dc_data_out), 64'(e.data));
                        check("dc_hit", 64'(dc_hit), 64'(e.hit));
                        check("dc_err", 64'(dc_err), 64'(e.err));
                        check("ic_data_held", 64'(ic_data_out), 64'(e.other));
                        check("ic_status_quiet", {62'd0, ic_hit, ic_err}, 64'd0);
                    end
                end
            end
        end
    end

    // L2 responder: checks the L2-side request and answers after the planned latency.
    initial begin
        plan_t pl;
        int    w;
        bit    done;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                l2_ready = 1'b0;
            end else if (!(l2_read || l2_write)) begin
                l2_ready   = ($urandom_range(0, 3) == 0);
                l2_data_in = $urandom;
                l2_hit     = 1'($urandom_range(0, 1));
            end else begin
                if (l2q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL l2_unexpected: got l2 request at 0x%0h expected none", l2_addr);
                    pl.abort = 1'b1; pl.lat = 1000; pl.addr = l2_addr; pl.wdata = l2_data_out;
                    pl.rd = l2_read; pl.wr = l2_write; pl.rdata = '0; pl.hit = 1'b0;
                end else begin
                    pl = l2q.pop_front();
                end
                check("l2_addr", 64'(l2_addr), 64'(pl.addr));
                check("l2_op", {62'd0, l2_read, l2_write}, {62'd0, pl.rd, pl.wr});
                check("l2_data_out", 64'(l2_data_out), 64'(pl.wdata));
                w = 0;
                done = 1'b0;
                while (!done) begin
                    if (w == pl.lat) begin
                        l2_ready = 1'b1; l2_data_in = pl.rdata; l2_hit = pl.hit;
                    end else begin
                        l2_ready = 1'b0; l2_data_in = $urandom; l2_hit = 1'($urandom_range(0, 1));
                    end
                    @(negedge clk);
                    if (!rst_n || !(l2_read || l2_write)) begin
                        done = 1'b1;
                    end else begin
                        w++;
                        check("l2_hold", {l2_addr, l2_data_out[29:0], l2_read, l2_write},
                              {pl.addr, pl.wdata[29:0], pl.rd, pl.wr});
                        if (w > 50) begin
                            n_checks++; n_fail++;
                            $display("FAIL l2_strobe_stuck: got %0d wait cycles expected <= %0d", w, TMO);
                            done = 1'b1;
                        end
                    end
                end
                l2_ready = rst_n ? 1'($urandom_range(0, 1)) : 1'b0;
                if (!pl.abort && rst_n)
                    check("wait_cycles", 64'(w + 1), 64'((pl.lat < TMO) ? pl.lat + 1 : TMO));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish by 500000");
        $fatal(1, "watchdog");
    end

    initial begin
        plan_t pl;
        int    mode;

        // Reset with a pending request: everything quiet.
        ic_read = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ic_out", {ic_data_out, 29'd0, ic_ready, ic_hit, ic_err}, 64'd0);
        check("rst_dc_out", {dc_data_out, 29'd0, dc_ready, dc_hit, dc_err}, 64'd0);
        check("rst_l2_out", {l2_addr, 30'd0, l2_read, l2_write}, 64'd0);
        check("rst_l2_data", {l2_data_out, 31'd0, busy}, 64'd0);
        ic_read = 1'b0;
        rst_n = 1'b1;

        // Contention straight after reset: ic wins first, then dc write.
        cur[0] = mk_req(1, 0, 32'h0000_1000, 32'h0, 1, 1, 32'hCAFE_0001);
        cur[1] = mk_req(0, 1, 32'h0000_2000, 32'h1234_5678, 0, 0, 32'h0BAD_F00D);
        do_round(1, 1);

        // Single ic read with an immediate hit.
        cur[0] = mk_req(1, 0, 32'h0000_1040, 32'h0, 0, 1, 32'hDEAD_BEEF);
        do_round(1, 0);

        // Continuous contention: six alternating grants.
        repeat (3) begin
            cur[0] = rand_req();
            cur[1] = rand_req();
            do_round(1, 1);
        end

        // Timeout with no L2 answer, then a normal transaction.
        cur[1] = mk_req(1, 0, 32'h0000_3000, 32'h0, 100, 1, 32'h0);
        do_round(0, 1);
        cur[1] = mk_req(1, 0, 32'h0000_3004, 32'h0, 2, 1, 32'h5555_AAAA);
        do_round(0, 1);

        // Reset during WAIT: strobe drops at once, no ready, request lost.
        cur[0] = mk_req(1, 0, 32'h0000_4000, 32'h0, 1000, 0, 32'h0);
        pl.addr = cur[0].addr; pl.wdata = cur[0].wdata; pl.rdata = '0;
        pl.rd = 1'b1; pl.wr = 1'b0; pl.hit = 1'b0; pl.abort = 1'b1; pl.lat = 1000;
        l2q.push_back(pl);
        @(negedge clk);
        drive_port(0, 1'b1);
        for (int n = 0; n < 20 && !l2_read; n++) @(negedge clk);
        check("pre_rst_l2_read", {63'd0, l2_read}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_l2_read", {62'd0, l2_read, busy}, 64'd0);
        check("mid_rst_ready", {62'd0, ic_ready, dc_ready}, 64'd0);
        drive_port(0, 1'b0);
        model_last = 1;
        model_data[0] = '0;
        model_data[1] = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cur[0] = mk_req(1, 0, 32'h0000_4000, 32'h0, 2, 1, 32'h7777_1111);
        do_round(1, 0);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            cur[0] = rand_req();
            cur[1] = rand_req();
            mode = $urandom_range(0, 2);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_round(mode != 1, mode != 0);
        end

        repeat (5) @(negedge clk);
        check("sb_drained", 64'(sb.size()), 64'd0);
        check("l2q_drained", 64'(l2q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
